csr_counter_register: RTL and testbench
=======================================

// Module: csr_counter_register
// PURPOSE
// - Parametrised free-running event/cycle counter exposed as a pair of CSRs (low/high word).
// - Successor to the single-word read-only CSR register: counter is WIDTH bits, software-writable, has inhibit and wrap pulse.
// - Instantiated per counter (mcycle/minstret style) on the core CSR bus; read data ORed with other CSR sources.
// PARAMETERS
// - ADDRESS_LOW      12'hB00         CSR address of counter[31:0]
// - ADDRESS_HIGH     12'hB80         CSR address of counter[WIDTH-1:32], zero-extended
// - ADDRESS_COMPARE  12'hBC0         CSR address of compare register (only with CSR_COUNTER_COMPARE_EN)
// - WIDTH            64              counter width, legal 33..64
// - WRITABLE         1               1: CSR writes load counter; 0: writes ignored, no write decode
// PORTS
// - clk               in   1   system clock
// - rst               in   1   synchronous, active-high reset
// - csrReadEnable     in   1   CSR read strobe
// - csrReadAddress    in   12  CSR read address
// - csrReadData       out  32  selected word, 32'b0 when not addressed
// - csrRequestOutput  out  1   this block drives csrReadData this cycle
// - csrWriteEnable    in   1   CSR write strobe
// - csrWriteAddress   in   12  CSR write address
// - csrWriteData      in   32  CSR write data
// - countEnable       in   1   increment request (one event per cycle)
// - countInhibit      in   1   suppresses increment while high
// - value             out  WIDTH  current counter value (registered)
// - overflow          out  1   one-cycle pulse when counter wraps all-ones -> 0
// - compareMatch      out  1   sticky match flag (tied 0 without CSR_COUNTER_COMPARE_EN)
// BEHAVIOUR
// - Reset: counter=0, overflow=0, compare=32'hFFFF_FFFF, compareMatch=0. Read path unaffected by rst (combinational).
// - Read: combinational, zero latency. Hit = csrReadEnable && address in {LOW, HIGH, COMPARE(if en)}.
//   csrRequestOutput=hit; csrReadData = counter[31:0] / {zeros, counter[WIDTH-1:32]} / compare; else 0.
//   Reads return pre-edge value; a same-cycle write/increment is visible next cycle.
// - Increment: inc = countEnable && !countInhibit; counter <= counter+1 mod 2^WIDTH on next edge.
//   overflow asserted the cycle after counter transitions all-ones -> 0 through increment only.
// - Write (WRITABLE=1), registered, visible next cycle; write beats increment per word:
//   - write LOW: counter[31:0] <= data; high word holds (no carry this cycle).
//   - write HIGH: counter[WIDTH-1:32] <= data[WIDTH-33:0] (excess bits dropped); low word still
//     increments if inc; carry out of low discarded this cycle.
//   - write to wrap point never generates overflow.
// - WRITABLE=0: writes ignored, counter only counts/resets; compare still writable.
// - Reset mid-count: rst wins over inc and write; no overflow pulse on reset.
// - Unrecognised addresses: no effect, no request.
// CONFIGURATION
// - CSR_COUNTER_COMPARE_EN defined:
//   - 32-bit compare register at ADDRESS_COMPARE, read/write, reset 32'hFFFF_FFFF.
//   - compareMatch set on edge after registered counter[31:0]==compare (checked every cycle);
//     stays set until a write to ADDRESS_COMPARE, which clears it (clear beats same-cycle set).
// - Not defined: no compare register, ADDRESS_COMPARE not decoded (no request), compareMatch=0.
// TESTING
// - Reset, countEnable=1 for 5 cycles -> value=5; read LOW -> csrReadData=5, csrRequestOutput=1.
// - Write HIGH=1, LOW=32'hFFFF_FFFE, count 3 -> value=64'h2_0000_0001, no overflow.
// - Write HIGH=32'hFFFF_FFFF, LOW=32'hFFFF_FFFF, count 1 -> value=0, overflow=1 for exactly 1 cycle.
// - countInhibit=1 with countEnable=1 for 10 cycles -> value unchanged; read HIGH addr mismatch -> data 0, request 0.
// - Write LOW=7 same cycle as inc -> next value[31:0]=7; WRITABLE=0 build -> write ignored, value increments.
// - COMPARE_EN: compare=20, count from 0 -> compareMatch rises after value=20, stays; write compare -> cleared.

Source files
------------

// File: rtl/csr_counter_register.sv
// ----------------------------------------------------------------------------
// csr_counter_register
//
// Free-running event/cycle counter (mcycle/minstret style) exposed on the core
// CSR bus as a low word and a zero-extended high word. Software may load
// either word when WRITABLE=1. Increments can be inhibited, and a one-cycle
// overflow pulse marks each wrap from all-ones to zero.
//
// Optional feature macro: CSR_COUNTER_COMPARE_EN
//   When defined, adds a 32-bit read/write compare register at
//   ADDRESS_COMPARE and a sticky compareMatch flag. When undefined,
//   ADDRESS_COMPARE is not decoded and compareMatch is tied low.
//
// Ports
//   clk              in   1      system clock
//   rst              in   1      synchronous active-high reset
//   csrReadEnable    in   1      CSR read strobe
//   csrReadAddress   in   12     CSR read address
//   csrReadData      out  32     selected word, zero when not addressed
//   csrRequestOutput out  1      this block drives csrReadData this cycle
//   csrWriteEnable   in   1      CSR write strobe
//   csrWriteAddress  in   12     CSR write address
//   csrWriteData     in   32     CSR write data
//   countEnable      in   1      increment request
//   countInhibit     in   1      suppresses increment while high
//   value            out  WIDTH  registered counter value
//   overflow         out  1      one-cycle pulse after an all-ones -> 0 wrap
//   compareMatch     out  1      sticky compare flag
// ----------------------------------------------------------------------------
module csr_counter_register #(
    parameter logic [11:0] ADDRESS_LOW     = 12'hB00,
    parameter logic [11:0] ADDRESS_HIGH    = 12'hB80,
    parameter logic [11:0] ADDRESS_COMPARE = 12'hBC0,
    parameter int unsigned WIDTH           = 64,
    parameter int unsigned WRITABLE        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csrReadEnable,
    input  logic [11:0]      csrReadAddress,
    output logic [31:0]      csrReadData,
    output logic             csrRequestOutput,
    input  logic             csrWriteEnable,
    input  logic [11:0]      csrWriteAddress,
    input  logic [31:0]      csrWriteData,
    input  logic             countEnable,
    input  logic             countInhibit,
    output logic [WIDTH-1:0] value,
    output logic             overflow,
    output logic             compareMatch
);

    localparam int unsigned HW    = WIDTH - 32;
    localparam bit          WR_EN = (WRITABLE != 0);

    logic [WIDTH-1:0] counter_q, counter_d;
    logic             overflow_q, overflow_d;
    logic             inc;
    logic             wr_low, wr_high;
    logic [31:0]      low_inc;
    logic [31:0]      high_word;

    assign inc     = countEnable && !countInhibit;
    assign wr_low  = WR_EN && csrWriteEnable && (csrWriteAddress == ADDRESS_LOW);
    assign wr_high = WR_EN && csrWriteEnable && (csrWriteAddress == ADDRESS_HIGH);
    assign low_inc = counter_q[31:0] + 32'd1;

    // A write to one word overrides the increment for that word only; the
    // carry between the words is dropped whenever either word is written.
    always_comb begin
        counter_d = counter_q;
        if (inc) begin
            counter_d = counter_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        if (wr_low) begin
            counter_d[31:0]       = csrWriteData;
            counter_d[WIDTH-1:32] = counter_q[WIDTH-1:32];
        end else if (wr_high) begin
            counter_d[WIDTH-1:32] = csrWriteData[HW-1:0];
            counter_d[31:0]       = inc ? low_inc : counter_q[31:0];
        end
    end

    // Only a genuine increment through the wrap point pulses overflow.
    assign overflow_d = inc && (&counter_q) && !wr_low && !wr_high;

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            overflow_q <= overflow_d;
        end
    end

    assign value    = counter_q;
    assign overflow = overflow_q;

    always_comb begin
        high_word         = '0;
        high_word[HW-1:0] = counter_q[WIDTH-1:32];
    end

`ifdef CSR_COUNTER_COMPARE_EN
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic        wr_cmp;

    // The compare register stays writable even when the counter is not.
    assign wr_cmp    = csrWriteEnable && (csrWriteAddress == ADDRESS_COMPARE);
    assign compare_d = wr_cmp ? csrWriteData : compare_q;

    // Clearing by a compare write takes priority over a same-cycle match.
    always_comb begin
        match_d = match_q;
        if (wr_cmp) begin
            match_d = 1'b0;
        end else if (counter_q[31:0] == compare_q) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            compare_q <= '1;
            match_q   <= 1'b0;
        end else begin
            compare_q <= compare_d;
            match_q   <= match_d;
        end
    end

    assign compareMatch = match_q;

    always_comb begin
        csrReadData      = '0;
        csrRequestOutput = 1'b0;
        if (csrReadEnable) begin
            if (csrReadAddress == ADDRESS_LOW) begin
                csrReadData      = counter_q[31:0];
                csrRequestOutput = 1'b1;
            end else if (csrReadAddress == ADDRESS_HIGH) begin
                csrReadData      = high_word;
                csrRequestOutput = 1'b1;
            end else if (csrReadAddress == ADDRESS_COMPARE) begin
                csrReadData      = compare_q;
                csrRequestOutput = 1'b1;
            end
        end
    end
`else
    logic unused_compare_addr;
    assign unused_compare_addr = ^ADDRESS_COMPARE;
    assign compareMatch        = 1'b0;

    always_comb begin
        csrReadData      = '0;
        csrRequestOutput = 1'b0;
        if (csrReadEnable) begin
            if (csrReadAddress == ADDRESS_LOW) begin
                csrReadData      = counter_q[31:0];
                csrRequestOutput = 1'b1;
            end else if (csrReadAddress == ADDRESS_HIGH) begin
                csrReadData      = high_word;
                csrRequestOutput = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_csr_counter_register.sv
module tb_csr_counter_register;

    localparam logic [11:0] A_L = 12'hB00;
    localparam logic [11:0] A_H = 12'hB80;
    localparam logic [11:0] A_C = 12'hBC0;

    logic        clk;
    logic        rst;
    logic        re;
    logic [11:0] raddr;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        cen;
    logic        cinh;

    logic [31:0] rdata0, rdata1;
    logic        req0, req1;
    logic [63:0] val0, val1;
    logic        ovf0, ovf1;
    logic        cm0, cm1;

    int n_cmp = 0;
    int n_err = 0;

    csr_counter_register #(
        .ADDRESS_LOW(A_L), .ADDRESS_HIGH(A_H), .ADDRESS_COMPARE(A_C),
        .WIDTH(64), .WRITABLE(1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .csrReadEnable(re), .csrReadAddress(raddr),
        .csrReadData(rdata0), .csrRequestOutput(req0),
        .csrWriteEnable(we), .csrWriteAddress(waddr), .csrWriteData(wdata),
        .countEnable(cen), .countInhibit(cinh),
        .value(val0), .overflow(ovf0), .compareMatch(cm0)
    );

    csr_counter_register #(
        .ADDRESS_LOW(A_L), .ADDRESS_HIGH(A_H), .ADDRESS_COMPARE(A_C),
        .WIDTH(64), .WRITABLE(0)
    ) u_ro (
        .clk(clk), .rst(rst),
        .csrReadEnable(re), .csrReadAddress(raddr),
        .csrReadData(rdata1), .csrRequestOutput(req1),
        .csrWriteEnable(we), .csrWriteAddress(waddr), .csrWriteData(wdata),
        .countEnable(cen), .countInhibit(cinh),
        .value(val1), .overflow(ovf1), .compareMatch(cm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, cen, cinh, we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        re;
        logic [11:0] raddr;
        logic [63:0] ev;
        logic        eo;
        logic [31:0] er;
        logic        ereq;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic c, logic i, logic w, logic [11:0] wa,
                                logic [31:0] wd, logic rd, logic [11:0] ra,
                                logic [63:0] ev, logic eo, logic [31:0] er, logic ereq);
        vec_t v;
        v.rst = r; v.cen = c; v.cinh = i; v.we = w; v.waddr = wa; v.wdata = wd;
        v.re = rd; v.raddr = ra; v.ev = ev; v.eo = eo; v.er = er; v.ereq = ereq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; cen = 1'b0; cinh = 1'b0; we = 1'b0;
        waddr = '0; wdata = '0; re = 1'b0; raddr = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();

        //          rst cen inh we  waddr  wdata          re  raddr  value                  ovf rdata          req
        vt.push_back(mk(1, 0, 0, 0, 12'h0, 32'h0,          0, 12'h0, 64'h0,                 0, 32'h0,          0));
        vt.push_back(mk(0, 1, 0, 0, 12'h0, 32'h0,          1, A_L,   64'h1,                 0, 32'h0,          1));
        vt.push_back(mk(0, 1, 0, 0, 12'h0, 32'h0,          0, 12'h0, 64'h2,                 0, 32'h0,          0));
        vt.push_back(mk(0, 1, 0, 0, 12'h0, 32'h0,          0, 12'h0, 64'h3,                 0, 32'h0,          0));
        vt.push_back(mk(0, 1, 0, 0, 12'h0, 32'h0,          0, 12'h0, 64'h4,                 0, 32'h0,          0));
        vt.push_back(mk(0, 1, 0, 0, 12'h0, 32'h0,          1, A_L,   64'h5,                 0, 32'h4,          1));
        vt.push_back(mk(0, 0, 0, 0, 12'h0, 32'h0,          1, A_L,   64'h5,                 0, 32'h5,          1));
        vt.push_back(mk(0, 0, 0, 1, A_H,   32'h1,          1, A_H,   64'h1_0000_0005,       0, 32'h0,          1));
        vt.push_back(mk(0, 0, 0, 1, A_L,   32'hFFFF_FFFE,  1, A_H,   64'h1_FFFF_FFFE,       0, 32'h1,          1));
        vt.push_back(mk(0, 1, 0, 0, 12'h0, 32'h0,          1, A_L,   64'h1_FFFF_FFFF,       0, 32'hFFFF_FFFE,  1));
        vt.push_back(mk(0, 1, 0, 0, 12'h0, 32'h0,          0, 12'h0, 64'h2_0000_0000,       0, 32'h0,          0));
        vt.push_back(mk(0, 1, 0, 0, 12'h0, 32'h0,          1, A_H,   64'h2_0000_0001,       0, 32'h2,          1));
        vt.push_back(mk(0, 0, 0, 1, A_H,   32'hFFFF_FFFF,  0, 12'h0, 64'hFFFF_FFFF_0000_0001, 0, 32'h0,        0));
        vt.push_back(mk(0, 0, 0, 1, A_L,   32'hFFFF_FFFF,  0, 12'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'h0,        0));
        vt.push_back(mk(0, 1, 0, 0, 12'h0, 32'h0,          1, A_L,   64'h0,                 1, 32'hFFFF_FFFF,  1));
        vt.push_back(mk(0, 0, 0, 0, 12'h0, 32'h0,          1, A_H,   64'h0,                 0, 32'h0,          1));
        vt.push_back(mk(0, 1, 1, 0, 12'h0, 32'h0,          1, 12'h123, 64'h0,               0, 32'h0,          0));
        vt.push_back(mk(0, 1, 0, 1, A_L,   32'h7,          0, 12'h0, 64'h7,                 0, 32'h0,          0));
        vt.push_back(mk(0, 1, 0, 1, A_H,   32'h5,          0, 12'h0, 64'h5_0000_0008,       0, 32'h0,          0));
        vt.push_back(mk(0, 0, 0, 1, A_L,   32'hFFFF_FFFF,  0, 12'h0, 64'h5_FFFF_FFFF,       0, 32'h0,          0));
        vt.push_back(mk(0, 1, 0, 1, A_H,   32'h3,          0, 12'h0, 64'h3_0000_0000,       0, 32'h0,          0));
        vt.push_back(mk(0, 0, 0, 1, 12'h123, 32'hAAAA,     1, 12'h7FF, 64'h3_0000_0000,     0, 32'h0,          0));
        vt.push_back(mk(1, 1, 0, 1, A_L,   32'h9,          0, 12'h0, 64'h0,                 0, 32'h0,          0));
        vt.push_back(mk(0, 0, 0, 1, A_L,   32'hFFFF_FFFF,  0, 12'h0, 64'h0000_0000_FFFF_FFFF, 0, 32'h0,        0));
        vt.push_back(mk(0, 0, 0, 1, A_H,   32'hFFFF_FFFF,  0, 12'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'h0,        0));
        vt.push_back(mk(0, 1, 0, 1, A_L,   32'h0,          0, 12'h0, 64'hFFFF_FFFF_0000_0000, 0, 32'h0,        0));
        vt.push_back(mk(0, 0, 0, 1, A_L,   32'hFFFF_FFFF,  0, 12'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'h0,        0));
        vt.push_back(mk(1, 1, 0, 0, 12'h0, 32'h0,          0, 12'h0, 64'h0,                 0, 32'h0,          0));

        foreach (vt[k]) begin
            rst = vt[k].rst; cen = vt[k].cen; cinh = vt[k].cinh; we = vt[k].we;
            waddr = vt[k].waddr; wdata = vt[k].wdata; re = vt[k].re; raddr = vt[k].raddr;
            #1;
            chk($sformatf("v%0d rdata", k), {32'h0, rdata0}, {32'h0, vt[k].er});
            chk($sformatf("v%0d req", k), {63'h0, req0}, {63'h0, vt[k].ereq});
            cyc();
            chk($sformatf("v%0d value", k), val0, vt[k].ev);
            chk($sformatf("v%0d ovf", k), {63'h0, ovf0}, {63'h0, vt[k].eo});
        end

        // inhibit holds the counter for many cycles
        idle();
        cen = 1'b1;
        repeat (4) cyc();
        chk("pre_inhibit", val0, 64'h4);
        cinh = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("inhibit%0d", i), val0, 64'h4);
        end
        idle();
        re = 1'b1; raddr = A_H + 12'h1;
        #1;
        chk("mis_rdata", {32'h0, rdata0}, 64'h0);
        chk("mis_req", {63'h0, req0}, 64'h0);
        idle();

        // write-protected instance ignores writes but keeps counting
        rst = 1'b1;
        cyc();
        idle();
        cen = 1'b1;
        repeat (3) cyc();
        chk("ro_cnt3", val1, 64'h3);
        we = 1'b1; waddr = A_L; wdata = 32'h7;
        cyc();
        chk("wr_low_inc", val0, 64'h7);
        chk("ro_low_ign", val1, 64'h4);
        waddr = A_H; wdata = 32'h9;
        cyc();
        chk("wr_high_inc", val0, 64'h9_0000_0008);
        chk("ro_high_ign", val1, 64'h5);
        idle();
        re = 1'b1; raddr = A_L;
        #1;
        chk("ro_rdata", {32'h0, rdata1}, 64'h5);
        chk("ro_req", {63'h0, req1}, 64'h1);
        idle();

`ifdef CSR_COUNTER_COMPARE_EN
        rst = 1'b1;
        cyc();
        idle();
        chk("cmp_rst_match", {63'h0, cm0}, 64'h0);
        we = 1'b1; waddr = A_C; wdata = 32'd20;
        cyc();
        idle();
        re = 1'b1; raddr = A_C;
        #1;
        chk("cmp_rdata", {32'h0, rdata0}, 64'd20);
        idle();
        cen = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (val0 == 64'd20) chk("cmp_at20", {63'h0, cm0}, 64'h0);
            if (val0 == 64'd21) chk("cmp_at21", {63'h0, cm0}, 64'h1);
        end
        idle();
        chk("cmp_sticky", {63'h0, cm0}, 64'h1);
        we = 1'b1; waddr = A_C; wdata = 32'd30;
        cyc();
        chk("cmp_clear", {63'h0, cm0}, 64'h0);
        idle();
        cyc();
        chk("cmp_reset30", {63'h0, cm0}, 64'h1);
        we = 1'b1; waddr = A_C; wdata = 32'd30;
        cyc();
        chk("cmp_clr_beats_set", {63'h0, cm0}, 64'h0);
        idle();
        cyc();
        chk("cmp_set_again", {63'h0, cm0}, 64'h1);
`else
        we = 1'b1; waddr = A_C; wdata = 32'h0;
        cyc();
        idle();
        cen = 1'b1;
        repeat (3) cyc();
        idle();
        chk("nocmp_match", {63'h0, cm0}, 64'h0);
        re = 1'b1; raddr = A_C;
        #1;
        chk("nocmp_rdata", {32'h0, rdata0}, 64'h0);
        chk("nocmp_req", {63'h0, req0}, 64'h0);
        idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
